trap_sequencer: RTL and testbench

- Consumes the per-instruction trap decision from the commit stage (trap_m/trap_s, cause, async flag) plus committed MRET/SRET.
- Sequences the architectural side effects: pipeline flush handshake, xEPC/xCAUSE/xTVAL/xSTATUS write strobes, privilege update, and front-end redirect.
- Owns the current privilege register; trap entry and trap return are the two directions of the same privilege-transfer interface.

---
 rtl/trap_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : trap_sequencer                                                   |
// | Brief   : Sequences trap entry / xRET side effects: flush, CSR strobes,    |
// |           privilege transfer and front-end redirect.                       |
// |           Optional vectored interrupt targets: define TRAP_VECTORED_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 64
`endif

module trap_sequencer #(
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               trap_m,
  input  logic               trap_s,
  input  logic               trap_async,
  input  logic [`XLEN-1:0]   trap_cause,
  input  logic [`XLEN-1:0]   trap_pc,
  input  logic [`XLEN-1:0]   trap_tval,
  input  logic               mret,
  input  logic               sret,
  input  logic [`XLEN-1:0]   csr_mtvec,
  input  logic [`XLEN-1:0]   csr_stvec,
  input  logic [`XLEN-1:0]   csr_mepc,
  input  logic [`XLEN-1:0]   csr_sepc,
  input  logic [`XLEN-1:0]   csr_mstatus,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic               csr_we_m,
  output logic               csr_we_s,
  output logic [`XLEN-1:0]   csr_epc_wdata,
  output logic [`XLEN-1:0]   csr_cause_wdata,
  output logic [`XLEN-1:0]   csr_tval_wdata,
  output logic               mstatus_we,
  output logic [`XLEN-1:0]   mstatus_wdata,
  output logic [1:0]         priv_o,
  output logic               redirect_valid,
  output logic [`XLEN-1:0]   redirect_pc,
  input  logic               redirect_ready
);

  localparam int c_xlen = `XLEN;

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_flush    = 2'd1;
  localparam logic [1:0] c_st_update   = 2'd2;
  localparam logic [1:0] c_st_redirect = 2'd3;

  localparam logic [1:0] c_ev_trap_m = 2'd0;
  localparam logic [1:0] c_ev_trap_s = 2'd1;
  localparam logic [1:0] c_ev_mret   = 2'd2;
  localparam logic [1:0] c_ev_sret   = 2'd3;

  localparam logic [1:0] c_priv_u = 2'b00;
  localparam logic [1:0] c_priv_s = 2'b01;
  localparam logic [1:0] c_priv_m = 2'b11;

  // mstatus field positions
  localparam int c_sie    = 1;
  localparam int c_mie    = 3;
  localparam int c_spie   = 5;
  localparam int c_mpie   = 7;
  localparam int c_spp    = 8;
  localparam int c_mpp_lo = 11;
  localparam int c_mprv   = 17;

  logic [1:0]        r_state;
  logic [1:0]        r_priv;
  logic [1:0]        r_kind;
  logic              r_async;
  logic [c_xlen-2:0] r_cause;
  logic [c_xlen-1:1] r_pc;
  logic [c_xlen-1:0] r_tval;
  logic [c_xlen-1:0] r_tvec;
  logic [c_xlen-1:0] r_xepc;
  logic [c_xlen-1:0] r_mstatus;

  logic              w_event;
  logic [1:0]        w_kind;
  logic              w_in_update;
  logic              w_is_trap;
  logic [c_xlen-1:0] w_new_mstatus;
  logic [1:0]        w_new_priv;
  logic [c_xlen-1:0] w_tvec_base;
  logic [c_xlen-1:0] w_trap_target;
  logic [c_xlen-1:0] w_redirect_target;
  logic              w_unused;

  assign req_ready = (r_state == c_st_idle);
  assign w_event   = req_valid & req_ready & (trap_m | trap_s | mret | sret);

  always_comb begin
    w_kind = c_ev_sret;
    if (trap_m)      w_kind = c_ev_trap_m;
    else if (trap_s) w_kind = c_ev_trap_s;
    else if (mret)   w_kind = c_ev_mret;
  end

  // Only the vector base and return address relevant to the winning event are kept.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state   <= c_st_idle;
      r_priv    <= RESET_PRIV;
      r_kind    <= c_ev_trap_m;
      r_async   <= 1'b0;
      r_cause   <= '0;
      r_pc      <= '0;
      r_tval    <= '0;
      r_tvec    <= '0;
      r_xepc    <= '0;
      r_mstatus <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_event) begin
            r_state   <= c_st_flush;
            r_kind    <= w_kind;
            r_async   <= trap_async;
            r_cause   <= trap_cause[c_xlen-2:0];
            r_pc      <= trap_pc[c_xlen-1:1];
            r_tval    <= trap_tval;
            r_tvec    <= trap_m ? csr_mtvec : csr_stvec;
            r_xepc    <= (w_kind == c_ev_mret) ? csr_mepc : csr_sepc;
            r_mstatus <= csr_mstatus;
          end
        end
        c_st_flush: begin
          if (flush_ack) r_state <= c_st_update;
        end
        c_st_update: begin
          r_state <= c_st_redirect;
          r_priv  <= w_new_priv;
        end
        c_st_redirect: begin
          if (redirect_ready) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_new_mstatus = r_mstatus;
    w_new_priv    = r_priv;
    case (r_kind)
      c_ev_trap_m: begin
        w_new_mstatus[c_mpie]         = r_mstatus[c_mie];
        w_new_mstatus[c_mie]          = 1'b0;
        w_new_mstatus[c_mpp_lo +: 2]  = r_priv;
        w_new_priv                    = c_priv_m;
      end
      c_ev_trap_s: begin
        w_new_mstatus[c_spie]         = r_mstatus[c_sie];
        w_new_mstatus[c_sie]          = 1'b0;
        w_new_mstatus[c_spp]          = r_priv[0];
        w_new_priv                    = c_priv_s;
      end
      c_ev_mret: begin
        w_new_mstatus[c_mie]          = r_mstatus[c_mpie];
        w_new_mstatus[c_mpie]         = 1'b1;
        w_new_mstatus[c_mpp_lo +: 2]  = c_priv_u;
        if (r_mstatus[c_mpp_lo +: 2] != c_priv_m) w_new_mstatus[c_mprv] = 1'b0;
        w_new_priv                    = r_mstatus[c_mpp_lo +: 2];
      end
      default: begin
        w_new_mstatus[c_sie]          = r_mstatus[c_spie];
        w_new_mstatus[c_spie]         = 1'b1;
        w_new_mstatus[c_spp]          = 1'b0;
        w_new_priv                    = {1'b0, r_mstatus[c_spp]};
      end
    endcase
  end

  assign w_tvec_base = {r_tvec[c_xlen-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  logic [c_xlen-1:0] w_vec_offset;
  // cause << 2, truncated to XLEN so the target wraps
  assign w_vec_offset  = {r_cause[c_xlen-3:0], 2'b00};
  assign w_trap_target = (r_async && (r_tvec[1:0] == 2'b01)) ? (w_tvec_base + w_vec_offset)
                                                             : w_tvec_base;
  assign w_unused      = ^{trap_cause[c_xlen-1], trap_pc[0]};
`else
  assign w_trap_target = w_tvec_base;
  assign w_unused      = ^{trap_cause[c_xlen-1], trap_pc[0], r_tvec[1:0]};
`endif

  assign w_in_update       = (r_state == c_st_update);
  assign w_is_trap         = (r_kind == c_ev_trap_m) || (r_kind == c_ev_trap_s);
  assign w_redirect_target = w_is_trap ? w_trap_target : r_xepc;

  assign flush_req       = (r_state == c_st_flush);
  assign csr_we_m        = w_in_update && (r_kind == c_ev_trap_m);
  assign csr_we_s        = w_in_update && (r_kind == c_ev_trap_s);
  assign csr_epc_wdata   = (w_in_update && w_is_trap) ? {r_pc, 1'b0} : '0;
  assign csr_cause_wdata = (w_in_update && w_is_trap) ? {r_async, r_cause} : '0;
  assign csr_tval_wdata  = (w_in_update && w_is_trap && !r_async) ? r_tval : '0;
  assign mstatus_we      = w_in_update;
  assign mstatus_wdata   = w_in_update ? w_new_mstatus : '0;
  assign priv_o          = r_priv;
  assign redirect_valid  = (r_state == c_st_redirect);
  assign redirect_pc     = redirect_valid ? w_redirect_target : '0;

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_trap_sequencer                                                |
// | Brief   : Self-checking bench for trap_sequencer: directed table, reset    |
// |           abort sequence and randomized events against a reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 64
`endif

module tb_trap_sequencer;

  localparam logic [63:0] c_top = 64'h8000_0000_0000_0000;
`ifdef TRAP_VECTORED_EN
  localparam logic [63:0] c_tgt3 = 64'h0000_0000_9000_0014;
  localparam logic [63:0] c_tgt9 = 64'h0000_0000_0000_0018;
`else
  localparam logic [63:0] c_tgt3 = 64'h0000_0000_9000_0000;
  localparam logic [63:0] c_tgt9 = 64'hFFFF_FFFF_FFFF_FFFC;
`endif

  typedef struct {
    logic        tm, ts, as, mr, sr;
    logic [63:0] cause, pc, tval, mtvec, stvec, mepc, sepc, mstatus;
    int          d, r;
    int          e_kind;  // 0 none, 1 trap M, 2 trap S, 3 xret
    logic [63:0] e_epc, e_cause, e_tval, e_ms, e_target;
    logic [1:0]  e_priv;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        srst_i, req_valid, req_ready, trap_m, trap_s, trap_async, mret, sret;
  logic [63:0] trap_cause, trap_pc, trap_tval;
  logic [63:0] csr_mtvec, csr_stvec, csr_mepc, csr_sepc, csr_mstatus;
  logic        flush_req, flush_ack, csr_we_m, csr_we_s, mstatus_we;
  logic [63:0] csr_epc_wdata, csr_cause_wdata, csr_tval_wdata, mstatus_wdata;
  logic [1:0]  priv_o;
  logic        redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;

  int          total = 0;
  int          bad = 0;
  logic [1:0]  m_priv;

  trap_sequencer #(.RESET_PRIV(2'b11)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .req_valid(req_valid), .req_ready(req_ready),
    .trap_m(trap_m), .trap_s(trap_s), .trap_async(trap_async), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .sret(sret),
    .csr_mtvec(csr_mtvec), .csr_stvec(csr_stvec), .csr_mepc(csr_mepc),
    .csr_sepc(csr_sepc), .csr_mstatus(csr_mstatus), .flush_req(flush_req),
    .flush_ack(flush_ack), .csr_we_m(csr_we_m), .csr_we_s(csr_we_s),
    .csr_epc_wdata(csr_epc_wdata), .csr_cause_wdata(csr_cause_wdata),
    .csr_tval_wdata(csr_tval_wdata), .mstatus_we(mstatus_we),
    .mstatus_wdata(mstatus_wdata), .priv_o(priv_o), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] getf(input logic [63:0] v, input int lsb, input int w);
    return (v >> lsb) % (64'd1 << w);
  endfunction

  function automatic logic [63:0] setf(input logic [63:0] v, input int lsb, input int w,
                                       input logic [63:0] f);
    logic [63:0] m;
    m = ((64'd1 << w) - 64'd1) << lsb;
    return (v & ~m) | ((f << lsb) & m);
  endfunction

  function automatic ev_t set_in(input logic tm, ts, as, mr, sr,
                                 input logic [63:0] cause, pc, tval, mtvec, stvec,
                                 input logic [63:0] mepc, sepc, ms, input int d, r);
    ev_t e;
    e.tm = tm; e.ts = ts; e.as = as; e.mr = mr; e.sr = sr;
    e.cause = cause; e.pc = pc; e.tval = tval; e.mtvec = mtvec; e.stvec = stvec;
    e.mepc = mepc; e.sepc = sepc; e.mstatus = ms; e.d = d; e.r = r;
    e.e_kind = 0; e.e_epc = 0; e.e_cause = 0; e.e_tval = 0; e.e_ms = 0;
    e.e_target = 0; e.e_priv = 0;
    return e;
  endfunction

  function automatic ev_t set_exp(input ev_t e, input int kind,
                                  input logic [63:0] epc, cause, tval, ms, target,
                                  input logic [1:0] priv);
    ev_t o = e;
    o.e_kind = kind; o.e_epc = epc; o.e_cause = cause; o.e_tval = tval;
    o.e_ms = ms; o.e_target = target; o.e_priv = priv;
    return o;
  endfunction

  function automatic ev_t rnd_ev();
    return set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, r64(), r64(), r64(),
                  r64(), r64(), r64(), r64(), r64(), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // Architectural reference: what the privileged spec says each event does.
  function automatic ev_t model(input ev_t e, input logic [1:0] p);
    ev_t o = e;
    logic [63:0] ms, tvec, base;
    logic [63:0] prev;
    ms = e.mstatus;
    prev = 64'(p);
    o.e_priv = p; o.e_kind = 0; o.e_epc = 0; o.e_cause = 0; o.e_tval = 0; o.e_target = 0;
    if (e.tm || e.ts) begin
      o.e_kind  = e.tm ? 1 : 2;
      tvec      = e.tm ? e.mtvec : e.stvec;
      o.e_epc   = e.pc - (e.pc % 2);
      o.e_cause = (e.cause % c_top) + (e.as ? c_top : 64'd0);
      o.e_tval  = e.as ? 64'd0 : e.tval;
      base      = tvec - (tvec % 4);
      o.e_target = base;
`ifdef TRAP_VECTORED_EN
      if (e.as && (tvec % 4) == 1) o.e_target = base + 64'd4 * (e.cause % c_top);
`endif
      if (e.tm) begin
        ms = setf(ms, 7, 1, getf(ms, 3, 1));
        ms = setf(ms, 3, 1, 0);
        ms = setf(ms, 11, 2, prev);
        o.e_priv = 2'b11;
      end else begin
        ms = setf(ms, 5, 1, getf(ms, 1, 1));
        ms = setf(ms, 1, 1, 0);
        ms = setf(ms, 8, 1, prev % 2);
        o.e_priv = 2'b01;
      end
    end else if (e.mr) begin
      o.e_kind = 3;
      o.e_priv = 2'(getf(ms, 11, 2));
      ms = setf(ms, 3, 1, getf(ms, 7, 1));
      ms = setf(ms, 7, 1, 1);
      ms = setf(ms, 11, 2, 0);
      if (o.e_priv != 2'b11) ms = setf(ms, 17, 1, 0);
      o.e_target = e.mepc;
    end else if (e.sr) begin
      o.e_kind = 3;
      o.e_priv = 2'(getf(ms, 8, 1));
      ms = setf(ms, 1, 1, getf(ms, 5, 1));
      ms = setf(ms, 5, 1, 1);
      ms = setf(ms, 8, 1, 0);
      o.e_target = e.sepc;
    end
    o.e_ms = ms;
    return o;
  endfunction

  task automatic drive(input ev_t e, input logic v);
    req_valid = v; trap_m = e.tm; trap_s = e.ts; trap_async = e.as;
    mret = e.mr; sret = e.sr; trap_cause = e.cause; trap_pc = e.pc; trap_tval = e.tval;
    csr_mtvec = e.mtvec; csr_stvec = e.stvec; csr_mepc = e.mepc; csr_sepc = e.sepc;
    csr_mstatus = e.mstatus;
  endtask

  // Called just after a falling edge with the DUT idle; returns on a falling edge, idle.
  task automatic run_ev(input ev_t e);
    int  upd, last, kmax;
    bit  empty;
    empty = (e.e_kind == 0);
    upd   = e.d + 2;
    last  = e.d + e.r + 3;
    kmax  = empty ? 1 : last + 1;
    chk("ready_before_event", req_ready, 1);
    drive(e, 1'b1);
    flush_ack = (e.d == 0);
    redirect_ready = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk_i);
      if (empty) begin
        chk("empty_req_ready", req_ready, 1);
        chk("empty_flush_req", flush_req, 0);
        chk("empty_mstatus_we", mstatus_we, 0);
        chk("empty_priv", priv_o, m_priv);
      end else begin
        chk("flush_req", flush_req, k <= e.d + 1);
        chk("req_ready", req_ready, k == last + 1);
        chk("csr_we_m", csr_we_m, (k == upd) && (e.e_kind == 1));
        chk("csr_we_s", csr_we_s, (k == upd) && (e.e_kind == 2));
        chk("mstatus_we", mstatus_we, k == upd);
        chk("redirect_valid", redirect_valid, (k > upd) && (k <= last));
        chk("priv_o", priv_o, (k > upd) ? e.e_priv : m_priv);
        if (k == upd) begin
          chk("mstatus_wdata", mstatus_wdata, e.e_ms);
          if (e.e_kind != 3) begin
            chk("epc_wdata", csr_epc_wdata, e.e_epc);
            chk("cause_wdata", csr_cause_wdata, e.e_cause);
            chk("tval_wdata", csr_tval_wdata, e.e_tval);
          end
        end
        if (k > upd && k <= last) chk("redirect_pc", redirect_pc, e.e_target);
      end
      flush_ack = (k == e.d + 1);
      redirect_ready = (k == last);
      if (!empty && k <= last) drive(rnd_ev(), 1'($urandom_range(0, 1)));
      else req_valid = 1'b0;
    end
    flush_ack = 1'b0;
    redirect_ready = 1'b0;
    req_valid = 1'b0;
    m_priv = e.e_priv;
  endtask

  ev_t tbl[10];
  ev_t e;

  initial begin
    tbl[0] = set_exp(set_in(0,0,0,1,0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                            64'h8000_1000, 64'h1234_0000, 64'h2_0080, 0, 0),
                     3, 0, 0, 0, 64'h88, 64'h8000_1000, 2'b00);
    tbl[1] = set_exp(set_in(1,0,0,0,0, 64'h8000_0000_0000_0002, 64'h8000_1002, 64'hFFFF,
                            64'h8000_0100, 64'h9000_0000, 64'hAAAA, 64'hBBBB, 64'h88, 0, 0),
                     1, 64'h8000_1002, 64'h2, 64'hFFFF, 64'h80, 64'h8000_0100, 2'b11);
    tbl[2] = set_exp(set_in(0,0,0,1,0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                            64'h8020_0000, 64'h0, 64'h2_0880, 2, 1),
                     3, 0, 0, 0, 64'h88, 64'h8020_0000, 2'b01);
    tbl[3] = set_exp(set_in(0,1,1,0,0, 64'h5, 64'h8020_0011, 64'h1234, 64'h8000_0101,
                            64'h9000_0001, 64'h0, 64'h0, 64'h1802, 5, 3),
                     2, 64'h8020_0010, 64'h8000_0000_0000_0005, 64'h0, 64'h1920, c_tgt3, 2'b01);
    tbl[4] = set_exp(set_in(0,0,0,0,1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                            64'h7777, 64'h8020_0100, 64'h1920, 1, 2),
                     3, 0, 0, 0, 64'h1822, 64'h8020_0100, 2'b01);
    tbl[5] = set_exp(set_in(1,0,0,1,0, 64'h9, 64'h8020_0200, 64'h0, 64'h8000_0101,
                            64'h0, 64'h5555, 64'h0, 64'h8, 1, 0),
                     1, 64'h8020_0200, 64'h9, 64'h0, 64'h880, 64'h8000_0100, 2'b11);
    tbl[6] = set_exp(set_in(0,0,1,0,0, 64'h3, 64'h44, 64'h55, 64'h66, 64'h77,
                            64'h88, 64'h99, 64'h8, 0, 0),
                     0, 0, 0, 0, 0, 0, 2'b11);
    tbl[7] = set_exp(set_in(0,1,0,1,1, 64'hD, 64'h1, 64'hDEAD, 64'h0, 64'h9000_0000,
                            64'h1111, 64'h2222, 64'h0, 0, 1),
                     2, 64'h0, 64'hD, 64'hDEAD, 64'h100, 64'h9000_0000, 2'b01);
    tbl[8] = set_exp(set_in(0,0,0,1,1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                            64'h8000_0000, 64'h9999, 64'h2_1800, 3, 0),
                     3, 0, 0, 0, 64'h2_0080, 64'h8000_0000, 2'b11);
    tbl[9] = set_exp(set_in(1,0,1,0,0, 64'h7, 64'h8000_0000, 64'h55,
                            64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 64'h0, 64'h0, 64'h8, 0, 0),
                     1, 64'h8000_0000, 64'h8000_0000_0000_0007, 64'h0, 64'h1880, c_tgt9, 2'b11);

    srst_i = 1'b1;
    flush_ack = 1'b0;
    redirect_ready = 1'b0;
    drive(set_in(0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0), 1'b0);
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_priv", priv_o, 2'b11);
    chk("rst_flush_req", flush_req, 0);
    chk("rst_strobes", {csr_we_m, csr_we_s, mstatus_we, redirect_valid}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_mstatus_wdata", mstatus_wdata, 0);
    chk("rst_epc_wdata", csr_epc_wdata, 0);
    srst_i = 1'b0;
    m_priv = 2'b11;

    for (int i = 0; i < 10; i++) run_ev(tbl[i]);

    // Reset during FLUSH abandons the event and restores the reset privilege.
    e = model(set_in(0,0,0,1,0, 0,0,0,0,0, 64'h4000, 0, 64'h0, 0, 0), m_priv);
    run_ev(e);
    chk("pre_reset_priv_u", priv_o, 2'b00);
    drive(set_in(1,0,0,0,0, 64'h2, 64'h100, 64'h0, 64'h200, 64'h0, 0, 0, 64'h8, 9, 0), 1'b1);
    @(negedge clk_i);
    chk("abort_in_flush", flush_req, 1);
    req_valid = 1'b0;
    srst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_flush_req", flush_req, 0);
    chk("abort_priv", priv_o, 2'b11);
    srst_i = 1'b0;
    flush_ack = 1'b1;
    redirect_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("abort_no_strobes", {csr_we_m, csr_we_s, mstatus_we, redirect_valid, flush_req}, 0);
    end
    flush_ack = 1'b0;
    redirect_ready = 1'b0;
    m_priv = 2'b11;

    for (int i = 0; i < 40; i++) begin
      e = rnd_ev();
      if ($urandom_range(0, 1) == 1) e.mtvec[1:0] = 2'b01;
      if ($urandom_range(0, 1) == 1) e.stvec[1:0] = 2'b01;
      e = model(e, m_priv);
      run_ev(e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
